// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: opcodes, packet field layout, mode/operation encodings
// and the opcode routing helper used by the instruction packer.
package cordic_pkg;

    localparam int PKT_W   = 108;
    localparam int TAG_MSB = 107;
    localparam int TAG_LSB = 100;
    localparam int OPC_MSB = 99;
    localparam int OPC_LSB = 96;
    localparam int Z_LSB   = 64;
    localparam int Y_LSB   = 32;
    localparam int X_LSB   = 0;

    localparam logic [3:0] DEFAULT_IDLE_OPCODE = 4'hF;

    localparam logic [3:0] OPC_ROTATION      = 4'd0;
    localparam logic [3:0] OPC_VECTORING     = 4'd1;
    localparam logic [3:0] OPC_HYP_ROTATION  = 4'd2;
    localparam logic [3:0] OPC_HYP_VECTORING = 4'd3;
    localparam logic [3:0] OPC_LIN_MULT      = 4'd4;
    localparam logic [3:0] OPC_SQR_ROOT      = 4'd5;
    localparam logic [3:0] OPC_LIN_DIV       = 4'd6;
    localparam logic [3:0] OPC_RSVD7         = 4'd7;
    localparam logic [3:0] OPC_RSVD8         = 4'd8;
    localparam logic [3:0] OPC_NAT_LOG       = 4'd9;
    localparam logic [3:0] OPC_EXP           = 4'd10;

    typedef enum logic [1:0] {
        MODE_CIRCULAR   = 2'd0,
        MODE_LINEAR     = 2'd1,
        MODE_HYPERBOLIC = 2'd2
    } cordic_mode_t;

    typedef enum logic {
        OP_ROTATE = 1'b0,
        OP_VECTOR = 1'b1
    } cordic_op_t;

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_X   = 2'd1,
        ST_Y   = 2'd2,
        ST_Z   = 2'd3
    } asm_state_t;

    typedef enum logic [1:0] {
        ROUTE_DIRECT = 2'd0,
        ROUTE_PREP   = 2'd1,
        ROUTE_DROP   = 2'd2
    } route_t;

    // sqr_root and nat_log need argument pre-processing; reserved/unknown opcodes are dropped
    function automatic route_t route_of(input logic [3:0] opc);
        route_t r;
        case (opc)
            OPC_ROTATION, OPC_VECTORING, OPC_HYP_ROTATION, OPC_HYP_VECTORING,
            OPC_LIN_MULT, OPC_LIN_DIV, OPC_EXP: r = ROUTE_DIRECT;
            OPC_SQR_ROOT, OPC_NAT_LOG:          r = ROUTE_PREP;
            default:                            r = ROUTE_DROP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fsl_instruction_packer_if.sv
// FSL slave channel, fetch-side presentation and pre-processor handshake of the packer.
interface fsl_instruction_packer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]               S_FSL_Data;
    logic                      S_FSL_Control;
    logic                      S_FSL_Exists;
    logic                      S_FSL_Read;
    logic                      stall;
    logic                      ProcessInputReady;
    logic [cordic_pkg::PKT_W-1:0] InstructionPacket;
    logic [cordic_pkg::PKT_W-1:0] PrepPacket;
    logic                      PrepValid;
    logic                      PrepReady;
    logic [OCC_W-1:0]          Occupancy;
    logic [7:0]                ErrCount;

    modport master (
        output S_FSL_Data, S_FSL_Control, S_FSL_Exists, stall, ProcessInputReady, PrepReady,
        input  S_FSL_Read, InstructionPacket, PrepPacket, PrepValid, Occupancy, ErrCount
    );

    modport slave (
        input  S_FSL_Data, S_FSL_Control, S_FSL_Exists, stall, ProcessInputReady, PrepReady,
        output S_FSL_Read, InstructionPacket, PrepPacket, PrepValid, Occupancy, ErrCount
    );

endinterface

// File: rtl/packet_fifo.sv
// Synchronous FIFO with a registered head output that shows EMPTY_VALUE when empty.
module packet_fifo #(
    parameter int               WIDTH       = 108,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] EMPTY_VALUE = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             do_pop, do_push;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != FULL_COUNT) || do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // The head register is refreshed from the entry that will be at the read pointer
    // after this edge; when that entry is the one being written now, bypass wr_data.
    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(do_pop);
        wr_ptr_next = wr_ptr_reg + AW'(do_push);
        count_next  = count_reg + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        head_next   = mem[rd_ptr_next];
        if (count_next == '0) begin
            head_next = EMPTY_VALUE;
        end else if (do_push && (count_next == (AW + 1)'(1))) begin
            head_next = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= EMPTY_VALUE;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign head  = head_reg;
    assign count = count_reg;
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/fsl_instruction_packer.sv
// Assembles FSL header/x/y/z words into 108-bit CORDIC packets and routes them to
// the direct fetch FIFO or the single-entry pre-processor slot.
module fsl_instruction_packer
    import cordic_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [3:0] IDLE_OPCODE = DEFAULT_IDLE_OPCODE
) (
    input logic                     clock,
    input logic                     reset,
    fsl_instruction_packer_if.slave bus
);
    localparam int               CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PKT_W-1:0] IDLE_PACKET = {8'h00, IDLE_OPCODE, 96'h0};

    asm_state_t       state_reg, state_next;
    logic [7:0]       tag_reg, tag_next;
    logic [3:0]       opc_reg, opc_next;
    logic [31:0]      x_reg, x_next;
    logic [31:0]      y_reg, y_next;
    logic [PKT_W-1:0] prep_packet_reg;
    logic             prep_valid_reg;
    logic [7:0]       err_count_reg;

    logic             word_valid, is_hdr, dest_ok, accept, take;
    logic             complete, err_inc;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [PKT_W-1:0] new_packet;
    route_t           route;

    assign word_valid = bus.S_FSL_Exists && !reset;
    assign is_hdr     = bus.S_FSL_Control;
    assign route      = route_of(opc_reg);
    assign fifo_pop   = !fifo_empty && !bus.stall && !bus.ProcessInputReady;
    assign new_packet = {tag_reg, opc_reg, bus.S_FSL_Data, y_reg, x_reg};

    // Only a z word can be back-pressured; a header in Z is a resync and never blocks.
    always_comb begin
        dest_ok = 1'b1;
        case (route)
            ROUTE_DIRECT: dest_ok = !fifo_full || fifo_pop;
            ROUTE_PREP:   dest_ok = !(prep_valid_reg && !bus.PrepReady);
            default:      dest_ok = 1'b1;
        endcase
    end

    assign accept         = (state_reg != ST_Z) || is_hdr || dest_ok;
    assign take           = word_valid && accept;
    assign bus.S_FSL_Read = take;

    always_comb begin
        state_next = state_reg;
        tag_next   = tag_reg;
        opc_next   = opc_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        complete   = 1'b0;
        err_inc    = 1'b0;
        if (take) begin
            if (is_hdr) begin
                tag_next   = bus.S_FSL_Data[7:0];
                opc_next   = bus.S_FSL_Data[11:8];
                state_next = ST_X;
                err_inc    = (state_reg != ST_HDR);
            end else begin
                case (state_reg)
                    ST_HDR: err_inc = 1'b1;
                    ST_X: begin
                        x_next     = bus.S_FSL_Data;
                        state_next = ST_Y;
                    end
                    ST_Y: begin
                        y_next     = bus.S_FSL_Data;
                        state_next = ST_Z;
                    end
                    default: begin
                        complete   = 1'b1;
                        state_next = ST_HDR;
                        err_inc    = (route == ROUTE_DROP);
                    end
                endcase
            end
        end
    end

    assign fifo_push = complete && (route == ROUTE_DIRECT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_HDR;
            tag_reg         <= '0;
            opc_reg         <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            prep_packet_reg <= '0;
            prep_valid_reg  <= 1'b0;
            err_count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tag_reg   <= tag_next;
            opc_reg   <= opc_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            if (complete && (route == ROUTE_PREP)) begin
                prep_packet_reg <= new_packet;
                prep_valid_reg  <= 1'b1;
            end else if (bus.PrepReady) begin
                prep_valid_reg  <= 1'b0;
            end
            if (err_inc && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    packet_fifo #(
        .WIDTH       (PKT_W),
        .DEPTH       (FIFO_DEPTH),
        .EMPTY_VALUE (IDLE_PACKET)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (new_packet),
        .pop     (fifo_pop),
        .head    (bus.InstructionPacket),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.Occupancy  = fifo_count;
    assign bus.PrepPacket = prep_packet_reg;
    assign bus.PrepValid  = prep_valid_reg;
    assign bus.ErrCount   = err_count_reg;

endmodule

// File: tb/tb_fsl_instruction_packer.sv
// Directed bench for fsl_instruction_packer: words are driven on the falling edge
// and outputs are checked on the falling edge against hand-computed packets.
module tb_fsl_instruction_packer;

    localparam int DEPTH = 4;
    localparam logic [107:0] IDLE_PKT = {8'h00, 4'hF, 96'h0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    fsl_instruction_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    fsl_instruction_packer #(
        .FIFO_DEPTH  (DEPTH),
        .IDLE_OPCODE (4'hF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [107:0] pkt(input logic [7:0] tag, input logic [3:0] opc,
                                         input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z);
        return {tag, opc, z, y, x};
    endfunction

    // Holds the word until it is popped; a word never popped counts as a miscompare.
    task automatic push_word(input logic [31:0] data, input logic ctrl);
        int   waited;
        logic rd;
        waited = 0;
        bus.S_FSL_Data    = data;
        bus.S_FSL_Control = ctrl;
        bus.S_FSL_Exists  = 1'b1;
        forever begin
            #1 rd = bus.S_FSL_Read;
            @(negedge clock);
            if (rd) break;
            waited++;
            if (waited > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL push_timeout: word %h never read (read=%b, want 1)", data, rd);
                break;
            end
        end
    endtask

    task automatic send_pkt(input logic [7:0] tag, input logic [3:0] opc,
                            input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        push_word({20'h0, opc, tag}, 1'b1);
        push_word(x, 1'b0);
        push_word(y, 1'b0);
        push_word(z, 1'b0);
        bus.S_FSL_Exists = 1'b0;
        $display("pkt tag=%h opc=%h x=%h y=%h z=%h", tag, opc, x, y, z);
    endtask

    task automatic test_reset();
        bus.S_FSL_Data    = 32'h0000_0307;
        bus.S_FSL_Control = 1'b1;
        bus.S_FSL_Exists  = 1'b1;
        #1;
        vectors++;
        if (bus.S_FSL_Read !== 1'b0) begin
            miscompares++; $display("FAIL reset_read: got %b want 0", bus.S_FSL_Read);
        end
        vectors++;
        if (bus.InstructionPacket !== IDLE_PKT) begin
            miscompares++; $display("FAIL reset_instr: got %h want %h", bus.InstructionPacket, IDLE_PKT);
        end
        vectors++;
        if (bus.PrepValid !== 1'b0 || bus.PrepPacket !== 108'h0) begin
            miscompares++; $display("FAIL reset_prep: got %b/%h want 0/0", bus.PrepValid, bus.PrepPacket);
        end
        vectors++;
        if (bus.Occupancy !== 3'd0 || bus.ErrCount !== 8'd0) begin
            miscompares++; $display("FAIL reset_counts: got occ=%0d err=%0d want 0/0", bus.Occupancy, bus.ErrCount);
        end
        bus.S_FSL_Exists = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        $display("reset done");
    endtask

    task automatic test_basic();
        logic [107:0] exp;
        exp = {8'h07, 4'h3, 32'h3F00_0000, 32'h0, 32'h3F80_0000};
        bus.stall = 1'b0;
        bus.ProcessInputReady = 1'b0;
        send_pkt(8'h07, 4'h3, 32'h3F80_0000, 32'h0, 32'h3F00_0000);
        vectors++;
        if (bus.InstructionPacket !== exp) begin
            miscompares++; $display("FAIL basic_present: got %h want %h", bus.InstructionPacket, exp);
        end
        vectors++;
        if (bus.Occupancy !== 3'd1) begin
            miscompares++; $display("FAIL basic_occ: got %0d want 1", bus.Occupancy);
        end
        @(negedge clock);
        vectors++;
        if (bus.InstructionPacket !== IDLE_PKT || bus.Occupancy !== 3'd0) begin
            miscompares++; $display("FAIL basic_idle: got %h occ=%0d want %h occ=0", bus.InstructionPacket, bus.Occupancy, IDLE_PKT);
        end
    endtask

    task automatic test_hold();
        logic [107:0] exp;
        exp = pkt(8'h08, 4'h3, 32'h3F80_0000, 32'h0, 32'h3F00_0000);
        bus.stall = 1'b1;
        send_pkt(8'h08, 4'h3, 32'h3F80_0000, 32'h0, 32'h3F00_0000);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.InstructionPacket !== exp) begin
                miscompares++; $display("FAIL stall_hold[%0d]: got %h want %h", i, bus.InstructionPacket, exp);
            end
            @(negedge clock);
        end
        bus.stall = 1'b0;
        vectors++;
        if (bus.InstructionPacket !== exp) begin
            miscompares++; $display("FAIL stall_last: got %h want %h", bus.InstructionPacket, exp);
        end
        @(negedge clock);
        vectors++;
        if (bus.InstructionPacket !== IDLE_PKT) begin
            miscompares++; $display("FAIL stall_consumed: got %h want %h", bus.InstructionPacket, IDLE_PKT);
        end

        exp = pkt(8'h09, 4'h0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F);
        bus.ProcessInputReady = 1'b1;
        send_pkt(8'h09, 4'h0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.InstructionPacket !== exp) begin
                miscompares++; $display("FAIL pir_hold[%0d]: got %h want %h", i, bus.InstructionPacket, exp);
            end
            @(negedge clock);
        end
        bus.ProcessInputReady = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus.InstructionPacket !== IDLE_PKT) begin
            miscompares++; $display("FAIL pir_consumed: got %h want %h", bus.InstructionPacket, IDLE_PKT);
        end
    endtask

    task automatic test_full();
        logic [107:0] fexp [5];
        logic [3:0]   opcs [5];
        opcs[0] = 4'd0; opcs[1] = 4'd1; opcs[2] = 4'd4; opcs[3] = 4'd6; opcs[4] = 4'd10;
        for (int t = 0; t < 5; t++) begin
            fexp[t] = pkt(8'h10 + 8'(t), opcs[t], 32'h100 + t, 32'h200 + t, 32'h300 + t);
        end
        bus.stall = 1'b1;
        for (int t = 0; t < 4; t++) begin
            send_pkt(8'h10 + 8'(t), opcs[t], 32'h100 + t, 32'h200 + t, 32'h300 + t);
            vectors++;
            if (bus.Occupancy !== 3'(t + 1)) begin
                miscompares++; $display("FAIL full_fill[%0d]: got occ=%0d want %0d", t, bus.Occupancy, t + 1);
            end
        end
        push_word({20'h0, 4'd10, 8'h14}, 1'b1);
        push_word(32'h104, 1'b0);
        push_word(32'h204, 1'b0);
        bus.S_FSL_Data    = 32'h304;
        bus.S_FSL_Control = 1'b0;
        bus.S_FSL_Exists  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.S_FSL_Read !== 1'b0 || bus.Occupancy !== 3'd4) begin
                miscompares++; $display("FAIL full_block[%0d]: got read=%b occ=%0d want 0/4", i, bus.S_FSL_Read, bus.Occupancy);
            end
            @(negedge clock);
        end
        bus.stall = 1'b0;
        #1;
        vectors++;
        if (bus.S_FSL_Read !== 1'b1) begin
            miscompares++; $display("FAIL full_accept: got read=%b want 1", bus.S_FSL_Read);
        end
        @(negedge clock);
        bus.S_FSL_Exists = 1'b0;
        for (int t = 1; t < 5; t++) begin
            vectors++;
            if (bus.InstructionPacket !== fexp[t] || bus.Occupancy !== 3'((t == 1) ? 4 : 5 - t)) begin
                miscompares++;
                $display("FAIL full_drain[%0d]: got %h occ=%0d want %h occ=%0d", t, bus.InstructionPacket,
                         bus.Occupancy, fexp[t], (t == 1) ? 4 : 5 - t);
            end
            @(negedge clock);
        end
        vectors++;
        if (bus.InstructionPacket !== IDLE_PKT || bus.Occupancy !== 3'd0) begin
            miscompares++; $display("FAIL full_empty: got %h occ=%0d want idle occ=0", bus.InstructionPacket, bus.Occupancy);
        end
    endtask

    task automatic test_prep();
        logic [107:0] exp1, exp2;
        exp1 = pkt(8'h21, 4'd5, 32'h4000_0000, 32'h3F80_0000, 32'h0);
        exp2 = pkt(8'h22, 4'd9, 32'h0000_0001, 32'h0000_0002, 32'h0000_3333);
        bus.stall = 1'b0;
        bus.PrepReady = 1'b0;
        send_pkt(8'h21, 4'd5, 32'h4000_0000, 32'h3F80_0000, 32'h0);
        vectors++;
        if (bus.PrepValid !== 1'b1 || bus.PrepPacket !== exp1) begin
            miscompares++; $display("FAIL prep_load: got %b/%h want 1/%h", bus.PrepValid, bus.PrepPacket, exp1);
        end
        vectors++;
        if (bus.InstructionPacket !== IDLE_PKT || bus.Occupancy !== 3'd0) begin
            miscompares++; $display("FAIL prep_not_direct: got %h occ=%0d want idle", bus.InstructionPacket, bus.Occupancy);
        end
        @(negedge clock);
        vectors++;
        if (bus.PrepValid !== 1'b1 || bus.PrepPacket !== exp1) begin
            miscompares++; $display("FAIL prep_hold: got %b/%h want 1/%h", bus.PrepValid, bus.PrepPacket, exp1);
        end
        push_word({20'h0, 4'd9, 8'h22}, 1'b1);
        push_word(32'h0000_0001, 1'b0);
        push_word(32'h0000_0002, 1'b0);
        bus.S_FSL_Data    = 32'h0000_3333;
        bus.S_FSL_Control = 1'b0;
        bus.S_FSL_Exists  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (bus.S_FSL_Read !== 1'b0) begin
                miscompares++; $display("FAIL prep_block[%0d]: got read=%b want 0", i, bus.S_FSL_Read);
            end
            @(negedge clock);
        end
        bus.PrepReady = 1'b1;
        #1;
        vectors++;
        if (bus.S_FSL_Read !== 1'b1) begin
            miscompares++; $display("FAIL prep_accept: got read=%b want 1", bus.S_FSL_Read);
        end
        @(negedge clock);
        bus.S_FSL_Exists = 1'b0;
        vectors++;
        if (bus.PrepValid !== 1'b1 || bus.PrepPacket !== exp2) begin
            miscompares++; $display("FAIL prep_reload: got %b/%h want 1/%h", bus.PrepValid, bus.PrepPacket, exp2);
        end
        @(negedge clock);
        vectors++;
        if (bus.PrepValid !== 1'b0) begin
            miscompares++; $display("FAIL prep_release: got %b want 0", bus.PrepValid);
        end
        bus.PrepReady = 1'b0;
    endtask

    task automatic test_errors();
        logic [107:0] exp;
        exp = pkt(8'h32, 4'd2, 32'h0000_000A, 32'h0000_000B, 32'h0000_000C);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.stall = 1'b0;
        push_word({20'h0, 4'd1, 8'h31}, 1'b1);
        push_word(32'h0000_0055, 1'b0);
        send_pkt(8'h32, 4'd2, 32'h0000_000A, 32'h0000_000B, 32'h0000_000C);
        vectors++;
        if (bus.ErrCount !== 8'd1) begin
            miscompares++; $display("FAIL err_resync: got %0d want 1", bus.ErrCount);
        end
        vectors++;
        if (bus.InstructionPacket !== exp) begin
            miscompares++; $display("FAIL err_after_resync: got %h want %h", bus.InstructionPacket, exp);
        end
        @(negedge clock);
        push_word(32'h0000_DEAD, 1'b0);
        bus.S_FSL_Exists = 1'b0;
        vectors++;
        if (bus.ErrCount !== 8'd2) begin
            miscompares++; $display("FAIL err_stray: got %0d want 2", bus.ErrCount);
        end
        send_pkt(8'h33, 4'd7, 32'h1, 32'h2, 32'h3);
        vectors++;
        if (bus.ErrCount !== 8'd3 || bus.InstructionPacket !== IDLE_PKT || bus.PrepValid !== 1'b0) begin
            miscompares++; $display("FAIL err_drop: got err=%0d instr=%h pv=%b want 3/idle/0", bus.ErrCount, bus.InstructionPacket, bus.PrepValid);
        end
        for (int i = 0; i < 252; i++) push_word(32'h0000_0BAD, 1'b0);
        bus.S_FSL_Exists = 1'b0;
        vectors++;
        if (bus.ErrCount !== 8'hFF) begin
            miscompares++; $display("FAIL err_reach_max: got %h want ff", bus.ErrCount);
        end
        for (int i = 0; i < 5; i++) push_word(32'h0000_0BAD, 1'b0);
        bus.S_FSL_Exists = 1'b0;
        vectors++;
        if (bus.ErrCount !== 8'hFF) begin
            miscompares++; $display("FAIL err_saturate: got %h want ff", bus.ErrCount);
        end
        $display("errors done");
    endtask

    task automatic test_reset_mid();
        logic [107:0] exp;
        exp = pkt(8'h45, 4'd6, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
        bus.stall = 1'b1;
        bus.PrepReady = 1'b0;
        send_pkt(8'h41, 4'd9, 32'h1, 32'h2, 32'h3);
        send_pkt(8'h42, 4'd0, 32'h4, 32'h5, 32'h6);
        send_pkt(8'h43, 4'd0, 32'h7, 32'h8, 32'h9);
        push_word({20'h0, 4'd1, 8'h44}, 1'b1);
        push_word(32'hAAAA_0001, 1'b0);
        push_word(32'hAAAA_0002, 1'b0);
        bus.S_FSL_Exists = 1'b0;
        vectors++;
        if (bus.Occupancy !== 3'd2 || bus.PrepValid !== 1'b1) begin
            miscompares++; $display("FAIL rmid_pre: got occ=%0d pv=%b want 2/1", bus.Occupancy, bus.PrepValid);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        vectors++;
        if (bus.Occupancy !== 3'd0 || bus.InstructionPacket !== IDLE_PKT || bus.PrepValid !== 1'b0) begin
            miscompares++; $display("FAIL rmid_cleared: got occ=%0d instr=%h pv=%b want 0/idle/0", bus.Occupancy, bus.InstructionPacket, bus.PrepValid);
        end
        bus.stall = 1'b0;
        send_pkt(8'h45, 4'd6, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
        vectors++;
        if (bus.InstructionPacket !== exp || bus.ErrCount !== 8'd0) begin
            miscompares++; $display("FAIL rmid_next: got %h err=%0d want %h err=0", bus.InstructionPacket, bus.ErrCount, exp);
        end
        @(negedge clock);
        vectors++;
        if (bus.InstructionPacket !== IDLE_PKT) begin
            miscompares++; $display("FAIL rmid_idle: got %h want %h", bus.InstructionPacket, IDLE_PKT);
        end
    endtask

    initial begin
        bus.S_FSL_Data        = 32'h0;
        bus.S_FSL_Control     = 1'b0;
        bus.S_FSL_Exists      = 1'b1;
        bus.stall             = 1'b0;
        bus.ProcessInputReady = 1'b0;
        bus.PrepReady         = 1'b0;
        reset                 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        test_reset();
        test_basic();
        test_hold();
        test_full();
        test_prep();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (vectors=%0d)", vectors);
        $fatal(1, "watchdog");
    end

endmodule
